// File: rtl/div_share_ctrl.sv
// Two-port front end for one shared multi-cycle divider: round-robin grant,
// launch/run/respond sequencing, divide-by-zero bypass and a run timeout.
module div_share_ctrl #(
  parameter int W       = 64,
  parameter int TIMEOUT = 256,
  parameter int CW      = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp0_valid,
  output logic         resp1_valid,
  output logic [W-1:0] resp_q,
  output logic [W-1:0] resp_r,
  output logic         resp_dz,
  output logic         resp_err,
  output logic         busy,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  output logic         div_rst,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  input  logic         div_rdy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          grant0, grant1;
  logic          accept;
  logic [W-1:0]  acc_a, acc_b;
  logic          rdy_hit, timeout_hit;

  // Request handshake: a request transfers on a rising edge where reqN_valid
  // and reqN_ready are both high; ready is only ever offered in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign accept = grant0 | grant1;
  assign acc_a  = grant1 ? req1_a : req0_a;
  assign acc_b  = grant1 ? req1_b : req0_b;

  // The first RUN cycle ignores div_rdy so a level left over from the
  // previous operation can never be mistaken for completion.
  assign rdy_hit     = (state == RUN) && div_rdy && (cnt != '0);
  assign timeout_hit = (state == RUN) && !rdy_hit && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (acc_b == '0) ? RESP : LAUNCH;
      LAUNCH:  state_nxt = RUN;
      RUN:     if (rdy_hit || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      div_a      <= '0;
      div_b      <= '0;
      resp_q     <= '0;
      resp_r     <= '0;
      resp_dz    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        if (acc_b == '0) begin
          resp_q   <= '1;
          resp_r   <= acc_a;
          resp_dz  <= 1'b1;
          resp_err <= 1'b0;
        end else begin
          div_a <= acc_a;
          div_b <= acc_b;
        end
      end
      if (state == LAUNCH) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
      end
      // Result registers only move on a capture, so they hold across IDLE.
      if (rdy_hit) begin
        resp_q   <= div_q;
        resp_r   <= div_r;
        resp_dz  <= 1'b0;
        resp_err <= 1'b0;
      end else if (timeout_hit) begin
        resp_q   <= '0;
        resp_r   <= '0;
        resp_dz  <= 1'b0;
        resp_err <= 1'b1;
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = (state == RESP) && !owner;
  assign resp1_valid = (state == RESP) && owner;
  assign div_rst     = (state != RUN);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: behavioural divider, request drivers, and a
// negedge scoreboard that predicts grants, timing and results from the rules.
module tb_div_share_ctrl;
  localparam int W       = 64;
  localparam int TIMEOUT = 256;
  localparam int CW      = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         resp0_valid, resp1_valid;
  logic [W-1:0] resp_q, resp_r;
  logic         resp_dz, resp_err, busy;
  logic [W-1:0] div_a, div_b;
  logic         div_rst;
  logic [W-1:0] div_q, div_r;
  logic         div_rdy;

  div_share_ctrl #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_q(resp_q), .resp_r(resp_r), .resp_dz(resp_dz), .resp_err(resp_err),
    .busy(busy), .div_a(div_a), .div_b(div_b), .div_rst(div_rst),
    .div_q(div_q), .div_r(div_r), .div_rdy(div_rdy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- divider model ----------------
  int   dly   = 1;
  bit   hang  = 1'b0;
  bit   stale = 1'b0;
  int   run_cnt = 0;
  logic good;

  always @(posedge clk) run_cnt <= div_rst ? 0 : run_cnt + 1;

  assign good    = !div_rst && (run_cnt >= dly) && (div_b != '0);
  assign div_rdy = (stale && (div_rst || run_cnt == 0)) || (!div_rst && !hang && run_cnt >= dly);
  assign div_q   = good ? div_a / div_b : 64'hBAD0_BAD0_BAD0_BAD0;
  assign div_r   = good ? div_a % div_b : 64'h0BAD_0BAD_0BAD_0BAD;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$], exp_r[$], exp_a[$], exp_b[$];
  int           exp_port[$], exp_acc[$], exp_cyc[$];
  bit           exp_dz[$], exp_err[$];
  bit           rr_last = 1'b1;
  logic [W-1:0] last_q = '0, last_r = '0;
  bit           last_dz = 1'b0, last_err = 1'b0;
  bit           eb, e0, e1, exp_dr, at_resp;

  function automatic void check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endfunction

  // Reference: quotient/remainder by plain arithmetic, response cycle from
  // the documented latency (cyc here is the cycle before the accept edge).
  function automatic void model_accept(int port, logic [W-1:0] a, logic [W-1:0] b);
    int k;
    exp_port.push_back(port);
    exp_acc.push_back(cyc);
    exp_a.push_back(a);
    exp_b.push_back(b);
    if (b == '0) begin
      exp_q.push_back({W{1'b1}}); exp_r.push_back(a);
      exp_dz.push_back(1'b1); exp_err.push_back(1'b0);
      exp_cyc.push_back(cyc + 1);
    end else begin
      k = (dly < 1) ? 1 : dly;
      if (hang || k > TIMEOUT - 1) begin
        exp_q.push_back('0); exp_r.push_back('0);
        exp_dz.push_back(1'b0); exp_err.push_back(1'b1);
        exp_cyc.push_back(cyc + 2 + TIMEOUT);
      end else begin
        exp_q.push_back(a / b); exp_r.push_back(a % b);
        exp_dz.push_back(1'b0); exp_err.push_back(1'b0);
        exp_cyc.push_back(cyc + 3 + k);
      end
    end
    rr_last = (port == 1);
  endfunction

  function automatic void clear_model();
    exp_q.delete(); exp_r.delete(); exp_a.delete(); exp_b.delete();
    exp_port.delete(); exp_acc.delete(); exp_cyc.delete();
    exp_dz.delete(); exp_err.delete();
    rr_last = 1'b1;
    last_q = '0; last_r = '0; last_dz = 1'b0; last_err = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      eb = (exp_port.size() != 0);
      e0 = !eb && req0_valid && (!req1_valid || rr_last == 1'b1);
      e1 = !eb && req1_valid && (!req0_valid || rr_last == 1'b0);
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      check("busy", busy, eb);
      exp_dr = 1'b1;
      if (eb && !exp_dz[0] && cyc >= exp_acc[0] + 2 && cyc < exp_cyc[0]) exp_dr = 1'b0;
      check("div_rst", div_rst, exp_dr);
      if (!exp_dr) begin
        check("div_a", div_a, exp_a[0]);
        check("div_b", div_b, exp_b[0]);
      end
      at_resp = eb && (cyc == exp_cyc[0]);
      check("resp0_valid", resp0_valid, at_resp && exp_port[0] == 0);
      check("resp1_valid", resp1_valid, at_resp && exp_port[0] == 1);
      if (at_resp) begin
        last_q = exp_q.pop_front(); last_r = exp_r.pop_front();
        last_dz = exp_dz.pop_front(); last_err = exp_err.pop_front();
        void'(exp_port.pop_front()); void'(exp_acc.pop_front()); void'(exp_cyc.pop_front());
        void'(exp_a.pop_front()); void'(exp_b.pop_front());
      end
      check("resp_q", resp_q, last_q);
      check("resp_r", resp_r, last_r);
      check("resp_dz", resp_dz, last_dz);
      check("resp_err", resp_err, last_err);
      if (e0) model_accept(0, req0_a, req0_b);
      else if (e1) model_accept(1, req1_a, req1_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int port, input logic [W-1:0] a, input logic [W-1:0] b);
    int  n = 0;
    bit  seen = 1'b0;
    @(posedge clk); #1;
    if (port == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else           begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    while (!seen && n < 600) begin
      @(negedge clk);
      seen = ((port == 0) ? req0_ready : req1_ready) === 1'b1;
      n++;
    end
    check("accept_wait", seen, 1'b1);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_port.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", exp_port.size() == 0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_div_rst", div_rst, 1'b1);
    check("rst_resp0", resp0_valid, 1'b0);
    check("rst_resp1", resp1_valid, 1'b0);
    check("rst_q", resp_q, '0);
    check("rst_r", resp_r, '0);
    check("rst_dz", resp_dz, 1'b0);
    check("rst_err", resp_err, 1'b0);
    check("rst_div_a", div_a, '0);
    check("rst_div_b", div_b, '0);
    clear_model();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] ra, rb, ra2, rb2;
    int           mode;

    do_reset();

    // single port 0 request, divider done 5 cycles after div_rst falls
    dly = 5;
    send(0, 500, 25);
    wait_idle();

    // simultaneous requests straight out of reset, then the same tie again
    do_reset();
    dly = 3;
    fork
      send(0, 100, 7);
      send(1, 81, 9);
    join
    wait_idle();
    fork
      send(0, 100, 7);
      send(1, 81, 9);
    join
    wait_idle();

    // port 0 served alone, so the following tie goes to port 1
    send(0, 7, 2);
    wait_idle();
    fork
      send(0, 45, 4);
      send(1, 64, 8);
    join
    wait_idle();

    // divide by zero bypasses the divider
    send(1, 1234, 0);
    wait_idle();

    // divider never answers, then a normal request
    hang = 1'b1;
    send(0, 777, 3);
    wait_idle();
    hang = 1'b0;
    dly  = 3;
    send(0, 60, 6);
    wait_idle();

    // stale ready during LAUNCH and first RUN cycle
    stale = 1'b1;
    dly   = 2;
    send(1, 1000, 7);
    wait_idle();
    stale = 1'b0;

    // asynchronous reset in the middle of RUN
    dly = 20;
    send(0, 900, 30);
    repeat (4) @(posedge clk);
    #3;
    do_reset();
    dly = 4;
    send(1, 99, 10);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      dly   = $urandom_range(0, 8);
      stale = ($urandom_range(0, 3) == 0);
      ra    = {$urandom, $urandom};
      ra2   = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = {$urandom, $urandom};
        default: rb = {32'h0, $urandom};
      endcase
      rb2  = W'($urandom_range(0, 20));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        send(0, ra, rb);
      end else if (mode == 1) begin
        send(1, ra, rb);
      end else begin
        fork
          send(0, ra, rb);
          send(1, ra2, rb2);
        join
      end
      wait_idle();
    end
    stale = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
